freq_window_checker: RTL and testbench
======================================

// Module: freq_window_checker
// PURPOSE
//   Measures the rate of a slow, asynchronous test signal, such as the MSB of a
//   counter running in a PLL output clock domain. It counts the signal's rising
//   edges over a fixed window of clk cycles and reports each window's count.
//   It flags lock (pass) once enough consecutive windows are in range, and flags
//   loss of lock (fail) afterwards. Sits downstream of the per-domain counters
//   and drives board LEDs and status outputs in the PLL feature tests.
// PARAMETERS
//   GATE_CYCLES  1024  clk cycles per measurement window (>=2)
//   CNT_WIDTH    16    width of the edge counter and of edge_count
//   EXP_MIN      60    lowest in-range edge count per window (inclusive)
//   EXP_MAX      68    highest in-range edge count per window (inclusive)
//   PASS_WINDOWS 4     consecutive in-range windows required to set pass (>=1)
// PORTS
//   clk         in   1          reference clock; all logic is in this domain
//   rst         in   1          reset: synchronous, active-high
//   sig_in      in   1          asynchronous signal being measured
//   en          in   1          measurement enable, level-sensitive
//   edge_count  out  CNT_WIDTH  edge count from the last completed window
//   count_valid out  1          1-cycle pulse when edge_count updates
//   in_range    out  1          last window satisfied EXP_MIN<=count<=EXP_MAX
//   pass        out  1          sticky: PASS_WINDOWS consecutive windows in range
//   fail        out  1          sticky: a window was out of range after pass was set
// BEHAVIOUR
//   - Reset: all outputs 0; FSM in IDLE; sync flops, timers and counters at 0.
//   - Synchroniser: sig_in feeds 2 flops (s1, s2), then a history flop s3.
//     Rising edge = s2 & ~s3. An edge is visible 3 clk cycles after sig_in rises.
//   - FSM states:
//       IDLE:   waits for en=1, then goes to SETTLE.
//       SETTLE: lasts exactly 4 cycles; edges are ignored; then goes to GATE.
//       GATE:   lasts exactly GATE_CYCLES cycles; each edge increments the edge
//               counter; the counter saturates at all-ones and does not wrap.
//       REPORT: lasts 1 cycle. It copies the counter into edge_count, pulses
//               count_valid, updates in_range, pass and fail, and clears the
//               counter. Any edge in this cycle is discarded.
//   - From REPORT: goes to GATE if en=1, otherwise to IDLE.
//     Window period is GATE_CYCLES+1 clk cycles.
//   - en=0 in SETTLE or GATE: the next state is IDLE. The partial window is
//     dropped: no count_valid, the counter is cleared, and consec is cleared.
//     edge_count, in_range, pass and fail keep their values.
//   - consec counter (saturates at PASS_WINDOWS), updated in REPORT:
//       in range:     consec+1; pass<=1 when the new value equals PASS_WINDOWS
//       out of range: consec<=0; fail<=1 only if pass is already 1
//   - pass and fail are cleared only by rst. Both may be 1 at the same time.
//   - Outputs are registered. edge_count, in_range and pass change in the same
//     cycle that count_valid is 1.
//   - rst overrides everything, including mid-window.
// TESTING
//   1 sig_in period 16 clk, en=1 -> count_valid every 1025 cycles, edge_count=64,
//     in_range=1; pass=1 at the 4th pulse.
//   2 After pass, sig_in period 32 clk -> next full window edge_count=32,
//     in_range=0, fail=1; pass remains 1.
//   3 Windows of 64, 64, 40, 64, 64, 64, 64 -> pass rises only at the 7th
//     window; fail stays 0.
//   4 en dropped 500 cycles into GATE -> no count_valid; the next window starts
//     after en=1 plus 4 SETTLE cycles, and consec restarts from 0.
//   5 CNT_WIDTH=4, sig_in period 4 clk -> edge_count=15 (saturated), in_range=0.
//   6 rst pulsed mid-GATE with pass=1 -> all outputs 0 on the next cycle; the
//     first count_valid comes 4+1024+1 cycles after rst falls.

Source files
------------

// File: rtl/freq_window_checker.sv
// Purpose : counts rising edges of an asynchronous slow signal over fixed clk windows,
//           reports each window's count and tracks lock (pass) / loss of lock (fail).
// Latency : sig_in edge visible 3 clk after it rises; results registered 1 clk after REPORT.
// Backpressure: none; free-running measurement, count_valid is a 1-cycle pulse per window.
//
// Ports:
//   clk          reference clock, all logic in this domain
//   rst          synchronous active-high reset
//   sig_in       asynchronous signal being measured (2-flop synchronised internally)
//   en           measurement enable; dropping it aborts the current window
//   edge_count   edge count of the last completed window (saturating)
//   count_valid  1-cycle pulse when edge_count/in_range/pass update
//   in_range     last window count within [EXP_MIN, EXP_MAX]
//   pass         sticky: PASS_WINDOWS consecutive in-range windows seen
//   fail         sticky: an out-of-range window after pass was set
module freq_window_checker #(
    parameter int unsigned GATE_CYCLES  = 1024,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned EXP_MIN      = 60,
    parameter int unsigned EXP_MAX      = 68,
    parameter int unsigned PASS_WINDOWS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 count_valid,
    output logic                 in_range,
    output logic                 pass,
    output logic                 fail
);

    // Timer must hold both the last SETTLE index (3) and GATE_CYCLES-1.
    localparam int unsigned TMR_W    = ($clog2(GATE_CYCLES) > 2) ? $clog2(GATE_CYCLES) : 2;
    localparam int unsigned CONSEC_W = $clog2(PASS_WINDOWS + 1);

    localparam logic [TMR_W-1:0]     SETTLE_LAST = TMR_W'(3);
    localparam logic [TMR_W-1:0]     GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CONSEC_W-1:0]  CONSEC_MAX  = CONSEC_W'(PASS_WINDOWS);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT     = '1;

    // Elaboration-time guards on parameter ranges the logic relies on.
    if (GATE_CYCLES < 2) begin : g_chk_gate
        $error("GATE_CYCLES must be at least 2");
    end
    if (PASS_WINDOWS < 1) begin : g_chk_pass
        $error("PASS_WINDOWS must be at least 1");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_chk_width
        $error("CNT_WIDTH must be in 1..32");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_REPORT
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser: s1/s2 resolve metastability, s3 holds history so a
    // rising edge is a single-cycle s2 & ~s3 pulse.
    // ------------------------------------------------------------------
    logic s1_q, s2_q, s3_q;
    logic edge_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign edge_det = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CONSEC_W-1:0]   consec_q, consec_d;
    logic [CNT_WIDTH-1:0]  edge_count_q, edge_count_d;
    logic                  count_valid_q, count_valid_d;
    logic                  in_range_q, in_range_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;

    // Helper values derived from the current state
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [CONSEC_W-1:0]   consec_inc;
    logic                  win_in_range;

    // Counter saturates at all-ones rather than wrapping, so an over-fast
    // signal can never alias back into the expected range.
    assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    assign consec_inc = (consec_q == CONSEC_MAX) ? consec_q : consec_q + CONSEC_W'(1);

    // Range compare at 32 bits so limits wider than CNT_WIDTH behave correctly.
    assign win_in_range = (32'(cnt_q) >= EXP_MIN) && (32'(cnt_q) <= EXP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            cnt_q         <= '0;
            consec_q      <= '0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            in_range_q    <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            cnt_q         <= cnt_d;
            consec_q      <= consec_d;
            edge_count_q  <= edge_count_d;
            count_valid_q <= count_valid_d;
            in_range_q    <= in_range_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cnt_d         = cnt_q;
        consec_d      = consec_q;
        edge_count_d  = edge_count_q;
        count_valid_d = 1'b0;
        in_range_d    = in_range_q;
        pass_d        = pass_q;
        fail_d        = fail_q;

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                cnt_d   = '0;
                if (en) begin
                    state_d = ST_SETTLE;
                end
            end

            // Lets the synchroniser flush stale history before counting.
            ST_SETTLE: begin
                if (!en) begin
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                    cnt_d    = '0;
                    consec_d = '0;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = ST_GATE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_GATE: begin
                if (!en) begin
                    // Partial window is dropped; reported outputs are held.
                    state_d  = ST_IDLE;
                    timer_d  = '0;
                    cnt_d    = '0;
                    consec_d = '0;
                end else begin
                    if (edge_det) begin
                        cnt_d = cnt_inc;
                    end
                    if (timer_q == GATE_LAST) begin
                        state_d = ST_REPORT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end

            // Single cycle: publish the window, edges seen here are discarded.
            ST_REPORT: begin
                edge_count_d  = cnt_q;
                count_valid_d = 1'b1;
                in_range_d    = win_in_range;
                cnt_d         = '0;
                timer_d       = '0;
                if (win_in_range) begin
                    consec_d = consec_inc;
                    if (consec_inc == CONSEC_MAX) begin
                        pass_d = 1'b1;
                    end
                end else begin
                    consec_d = '0;
                    if (pass_q) begin
                        fail_d = 1'b1;
                    end
                end
                state_d = en ? ST_GATE : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign edge_count  = edge_count_q;
    assign count_valid = count_valid_q;
    assign in_range    = in_range_q;
    assign pass        = pass_q;
    assign fail        = fail_q;

endmodule

// File: tb/tb_freq_window_checker.sv
module tb_freq_window_checker;

    localparam int G    = 1024;
    localparam int W    = 16;
    localparam int EMIN = 60;
    localparam int EMAX = 68;
    localparam int PW   = 4;
    localparam int G2   = 64;
    localparam int W2   = 4;
    localparam int HIST = 65536;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          sig_in;
    logic [W-1:0]  edge_count;
    logic          count_valid, in_range, pass, fail;

    logic          en2;
    logic          sig_in2;
    logic [W2-1:0] edge_count2;
    logic          count_valid2, in_range2, pass2, fail2;

    freq_window_checker dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .en          (en),
        .edge_count  (edge_count),
        .count_valid (count_valid),
        .in_range    (in_range),
        .pass        (pass),
        .fail        (fail)
    );

    freq_window_checker #(
        .GATE_CYCLES  (G2),
        .CNT_WIDTH    (W2),
        .PASS_WINDOWS (1)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in2),
        .en          (en2),
        .edge_count  (edge_count2),
        .count_valid (count_valid2),
        .in_range    (in_range2),
        .pass        (pass2),
        .fail        (fail2)
    );

    always #5 clk = ~clk;

    // cyc = number of posedges so far; sig_hist[n] = sig_in sampled at posedge n
    int cyc    = 0;
    int cv_cnt = 0;
    bit sig_hist [0:HIST-1];

    always @(posedge clk) begin
        if (cyc < HIST) sig_hist[cyc] = sig_in;
        if (count_valid) cv_cnt = cv_cnt + 1;
        cyc = cyc + 1;
    end

    // Square-wave generators, period changeable at run time
    int per = 16;
    initial begin
        int ph;
        sig_in = 1'b0;
        ph = $urandom_range(0, 15);
        forever begin
            @(negedge clk);
            ph = (ph + 1 >= per) ? 0 : ph + 1;
            sig_in = (ph < per / 2);
        end
    end

    initial begin
        int ph2;
        sig_in2 = 1'b0;
        ph2 = $urandom_range(0, 3);
        forever begin
            @(negedge clk);
            ph2 = (ph2 + 1) % 4;
            sig_in2 = (ph2 < 2);
        end
    end

    // Reference model state
    int checks = 0;
    int errors = 0;
    int m_consec;
    bit m_pass, m_fail;
    int m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Rising edges seen by a window whose counting cycles are g0..g0+gates-1:
    // the cycle m counts when the input was low at posedge m-2 and high at m-1.
    function automatic int model_count(input int g0, input int gates, input int width);
        int c = 0;
        for (int m = g0; m < g0 + gates; m++)
            if (sig_hist[m-1] && !sig_hist[m-2]) c++;
        if (c > (1 << width) - 1) c = (1 << width) - 1;
        return c;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_window(input int g0, input string tag);
        int c;
        bit ir;
        wait_until(g0 + G + 1);
        chk({tag, ".cv_quiet"}, 32'(count_valid), 0);
        @(negedge clk);
        c  = model_count(g0, G, W);
        ir = (c >= EMIN) && (c <= EMAX);
        if (ir) begin
            m_consec = (m_consec < PW) ? m_consec + 1 : PW;
            if (m_consec == PW) m_pass = 1'b1;
        end else begin
            m_consec = 0;
            if (m_pass) m_fail = 1'b1;
        end
        m_last = c;
        chk({tag, ".cv"},       32'(count_valid), 1);
        chk({tag, ".count"},    32'(edge_count), c);
        chk({tag, ".in_range"}, 32'(in_range), 32'(ir));
        chk({tag, ".pass"},     32'(pass), 32'(m_pass));
        chk({tag, ".fail"},     32'(fail), 32'(m_fail));
    endtask

    // Assert rst for one posedge, check outputs cleared, release. p is the
    // first posedge that sees rst low (en is held high), i.e. SETTLE start.
    task automatic do_reset(input string tag, output int p);
        rst = 1'b1;
        @(negedge clk);
        chk({tag, ".count"},    32'(edge_count), 0);
        chk({tag, ".cv"},       32'(count_valid), 0);
        chk({tag, ".in_range"}, 32'(in_range), 0);
        chk({tag, ".pass"},     32'(pass), 0);
        chk({tag, ".fail"},     32'(fail), 0);
        rst = 1'b0;
        p = cyc;
        m_consec = 0;
        m_pass   = 1'b0;
        m_fail   = 1'b0;
        m_last   = 0;
    endtask

    initial begin
        int p, g, bad, e2, cv0;
        int bad_tab [4];
        bit ir2;
        bad_tab = '{20, 24, 32, 40};
        rst = 1'b1;
        en  = 1'b1;
        en2 = 1'b1;
        @(negedge clk);
        do_reset("reset", p);
        chk("reset.cv2", 32'(count_valid2), 0);

        // Narrow counter: period-4 input over a 64-cycle window saturates
        e2  = G2 / 4;
        if (e2 > (1 << W2) - 1) e2 = (1 << W2) - 1;
        ir2 = (e2 >= EMIN) && (e2 <= EMAX);
        g = p + 4;
        for (int w = 0; w < 2; w++) begin
            wait_until(g + G2 + 1);
            chk("sat.cv_quiet", 32'(count_valid2), 0);
            @(negedge clk);
            chk("sat.cv",       32'(count_valid2), 1);
            chk("sat.count",    32'(edge_count2), e2);
            chk("sat.in_range", 32'(in_range2), 32'(ir2));
            chk("sat.pass",     32'(pass2), 32'(ir2));
            chk("sat.fail",     32'(fail2), 0);
            g = g + G2 + 1;
        end

        // Lock at period 16, then slow to period 32 for loss of lock
        g = p + 4;
        for (int w = 0; w < 5; w++) begin
            if (w == 3) begin
                wait_until(g + G - 40);
                per = 32;
            end
            check_window(g, "lock");
            g = g + G + 1;
        end

        // Reset in the middle of a window with pass and fail set
        per = 16;
        wait_until(g + $urandom_range(50, 900));
        do_reset("midrst", p);

        // Enable dropped part-way through the third window
        g = p + 4;
        for (int w = 0; w < 2; w++) begin
            check_window(g, "pre_drop");
            g = g + G + 1;
        end
        wait_until(g + 500 + $urandom_range(0, 20));
        en = 1'b0;
        @(negedge clk);
        cv0 = cv_cnt;
        m_consec = 0;
        repeat (10 + $urandom_range(0, 20)) @(negedge clk);
        chk("drop.count_held", 32'(edge_count), m_last);
        chk("drop.pass_held",  32'(pass), 32'(m_pass));
        en = 1'b1;
        p = cyc;
        g = p + 4;
        wait_until(g + G + 1);
        chk("drop.no_cv", cv_cnt, cv0);
        for (int w = 0; w < 4; w++) begin
            check_window(g, "post_drop");
            g = g + G + 1;
        end

        // One bad window in the run: consec restarts, pass comes late
        do_reset("rst2", p);
        bad = bad_tab[$urandom_range(0, 3)];
        g = p + 4;
        for (int w = 0; w < 7; w++) begin
            if (w == 1) begin
                wait_until(g + G - 40);
                per = bad;
            end
            if (w == 2) begin
                wait_until(g + G - 40);
                per = 16;
            end
            check_window(g, "consec");
            g = g + G + 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 80000);
        $fatal(1, "watchdog expired");
    end

endmodule
